// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] END_OF_PROG = 32'h0000_0000;

   typedef enum logic [1:0] {FETCH, DRAIN, DONE} fetch_state_e;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // ROM words arrive in file byte order; instructions are little-endian.
   function automatic logic [INSTR_W-1:0] assemble(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ROM, decode-side handshake and redirect signals of the fetch unit.
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int ROM_DEPTH = 256
);
   localparam int AW = addr_w(ROM_DEPTH);

   logic [AW-1:0]      rom_addr;
   logic [INSTR_W-1:0] rom_data;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [31:0]        out_pc;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic               fetch_complete;

   modport master (
      output rom_addr, out_valid, out_instr, out_pc, fetch_complete,
      input  rom_data, out_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  rom_addr, out_valid, out_instr, out_pc, fetch_complete,
      output rom_data, out_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Two-entry FIFO with synchronous clear; head is presented combinationally.
module fetch_fifo #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [1:0]       count_o
);

   logic [1:0][WIDTH-1:0] mem_q;
   logic                  rd_ptr_q, wr_ptr_q;
   logic [1:0]            count_q;
   logic                  do_push, do_pop;

   assign do_pop  = pop_i && (count_q != 2'd0);
   assign do_push = push_i && ((count_q != 2'd2) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (clr_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(do_push) - 2'(do_pop);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch from a synchronous ROM into a 2-deep buffer,
// stopping at the all-zero end marker or the last ROM word.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          ROM_DEPTH = 256,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);

   localparam int          AW        = addr_w(ROM_DEPTH);
   localparam logic [31:0] ROM_BYTES = 32'(ROM_DEPTH) << 2;
   localparam logic [29:0] LAST_IDX  = 30'(ROM_DEPTH - 1);

   fetch_state_e state_q;
   logic [31:0]  pc_q, inflight_pc_q, redir_pc;
   logic         inflight_q;
   logic [1:0]   occ;
   logic [2:0]   load;
   logic         pop, push, issue, resp_zero, last_word;
   logic [31:0]  resp_instr;
   fetch_entry_t head, push_entry;

   assign resp_instr = assemble(bus.rom_data);
   assign resp_zero  = inflight_q && (resp_instr == END_OF_PROG);
   assign push       = inflight_q && !resp_zero;
   assign pop        = bus.out_valid && bus.out_ready;
   assign redir_pc   = bus.redirect_pc & ~32'h3;
   assign last_word  = (pc_q[31:2] == LAST_IDX);

   // Count both buffered and in-flight words so a returning response always has a slot.
   assign load  = 3'(occ) + 3'(inflight_q) - 3'(pop);
   assign issue = (state_q == FETCH) && !resp_zero && !bus.redirect_valid && (load < 3'd2);

   assign push_entry = '{pc: inflight_pc_q, instr: resp_instr};

   fetch_fifo #(.WIDTH($bits(fetch_entry_t))) u_fifo (
      .clk         (clk),
      .rst         (reset),
      .clr_i       (bus.redirect_valid),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (occ)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else if (bus.redirect_valid) begin
         pc_q       <= redir_pc;
         inflight_q <= 1'b0;
         state_q    <= (redir_pc >= ROM_BYTES) ? DRAIN : FETCH;
      end else begin
         inflight_q <= issue;
         if (issue) inflight_pc_q <= pc_q;
         case (state_q)
            FETCH: begin
               if (resp_zero) state_q <= DRAIN;
               else if (issue) begin
                  // pc parks on the last word so rom_addr never wraps.
                  if (last_word) state_q <= DRAIN;
                  else           pc_q    <= pc_q + 32'd4;
               end
            end
            DRAIN:   if ((occ == 2'd0) && !inflight_q) state_q <= DONE;
            DONE:    ;
            default: state_q <= FETCH;
         endcase
      end
   end

   assign bus.rom_addr       = (pc_q >= ROM_BYTES) ? AW'(ROM_DEPTH - 1) : pc_q[AW+1:2];
   assign bus.out_valid      = (occ != 2'd0);
   assign bus.out_instr      = head.instr;
   assign bus.out_pc         = head.pc;
   assign bus.fetch_complete = (state_q == DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a byte-level ROM model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int          DEPTH = 16;
   localparam logic [31:0] RPC   = 32'h0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fetch_unit_if #(.ROM_DEPTH(DEPTH)) bus ();
   fetch_unit #(.ROM_DEPTH(DEPTH), .RESET_PC(RPC)) dut (.clk(clk), .reset(reset), .bus(bus));

   logic [7:0] mem [DEPTH*4];
   exp_t       q[$];
   int         pop_cyc[$];
   int         cyc = 0;
   int         checks = 0, passed = 0;
   bit         hold_prev = 0, hold_exempt = 0;
   logic [31:0] hold_pc, hold_instr;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous ROM: the word is returned in file byte order one cycle later.
   always @(posedge clk) begin : rom_p
      int a;
      a = int'(bus.rom_addr) * 4;
      bus.rom_data <= {mem[a], mem[a+1], mem[a+2], mem[a+3]};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic set_word(input int i, input logic [31:0] instr);
      for (int k = 0; k < 4; k++) mem[4*i+k] = instr[8*k +: 8];
   endtask

   task automatic load_random(input int zero_at);
      for (int i = 0; i < DEPTH; i++)
         set_word(i, (i == zero_at) ? 32'h0 : ($urandom() | 32'h1));
   endtask

   // Expected stream: consecutive little-endian words from start until a zero word or ROM end.
   function automatic void expect_from(input logic [31:0] start);
      logic [31:0] w;
      q.delete();
      if (start >= 32'(DEPTH * 4)) return;
      for (int i = int'(start[31:2]); i < DEPTH; i++) begin
         w = 32'(mem[4*i]) + (32'(mem[4*i+1]) << 8) + (32'(mem[4*i+2]) << 16) + (32'(mem[4*i+3]) << 24);
         if (w == 32'h0) break;
         q.push_back('{pc: 32'(i * 4), instr: w});
      end
   endfunction

   always @(negedge clk) begin : monitor_p
      exp_t e;
      if (hold_prev && !hold_exempt) begin
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_pc", bus.out_pc, hold_pc);
         check("hold_instr", bus.out_instr, hold_instr);
      end
      hold_exempt = 0;
      if (bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output: got pc %h instr %h expected none", bus.out_pc, bus.out_instr);
         end else begin
            e = q.pop_front();
            check("out_pc", bus.out_pc, e.pc);
            check("out_instr", bus.out_instr, e.instr);
         end
         pop_cyc.push_back(cyc);
      end
      hold_prev  = bus.out_valid && !bus.out_ready && !bus.redirect_valid && !reset;
      hold_pc    = bus.out_pc;
      hold_instr = bus.out_instr;
   end

   task automatic redirect(input logic [31:0] pc);
      @(posedge clk); #2;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
      @(negedge clk); #1;
      expect_from(pc);
      @(posedge clk); #2;
      bus.redirect_valid = 1'b0;
   endtask

   task automatic cycles(input bit rnd, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #2;
         bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   endtask

   task automatic run(input bit rnd, input int budget);
      bit done = 0, seen_last = 0, wrapped = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk); #2;
         bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk); #1;
         if (int'(bus.rom_addr) == DEPTH - 1) seen_last = 1;
         else if (seen_last && bus.rom_addr == '0) wrapped = 1;
         done = bus.fetch_complete;
      end
      check("complete", 32'(done), 32'd1);
      check("drained", 32'(q.size()), 32'd0);
      check("no_wrap", 32'(wrapped), 32'd0);
      check("done_valid", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin : stim_p
      int c0, w;
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      for (int i = 0; i < DEPTH * 4; i++) mem[i] = 8'h00;
      set_word(0, 32'h0010_0513);
      set_word(1, 32'h0020_0593);
      #1 reset = 1'b1;
      #2;
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_complete", 32'(bus.fetch_complete), 32'd0);
      check("rst_instr", bus.out_instr, 32'h0);
      check("rst_pc", bus.out_pc, 32'h0);
      repeat (2) @(posedge clk);

      // Two-instruction program terminated by the zero word.
      expect_from(RPC);
      pop_cyc.delete();
      @(posedge clk); #2;
      bus.out_ready = 1'b1;
      c0 = cyc;
      reset = 1'b0;
      run(0, 100);
      check("basic_pops", 32'(pop_cyc.size()), 32'd2);
      if (pop_cyc.size() >= 2) begin
         check("first_latency", 32'(pop_cyc[0] - c0), 32'd2);
         check("back_to_back", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      end

      // Backpressure then random release; zero word at index 10.
      load_random(10);
      bus.out_ready = 1'b0;
      redirect(32'h0);
      w = 0;
      while (!bus.out_valid && w < 20) begin @(negedge clk); w++; end
      check("valid_seen", 32'(bus.out_valid), 32'd1);
      repeat (5) @(negedge clk);
      check("outstanding", 32'(bus.rom_addr <= 2), 32'd1);
      run(1, 300);

      // Full throughput with ready held high.
      load_random(12);
      redirect(32'h0);
      pop_cyc.delete();
      run(0, 100);
      check("stream_pops", 32'(pop_cyc.size()), 32'd12);
      if (pop_cyc.size() == 12)
         check("stream_span", 32'(pop_cyc[11] - pop_cyc[0]), 32'd11);

      // Redirect to an unaligned address while the buffer is full.
      load_random(-1);
      bus.out_ready = 1'b0;
      redirect(32'h0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("full_addr", 32'(bus.rom_addr), 32'd2);
      redirect(32'h0000_0023);
      @(negedge clk);
      check("redir_valid", 32'(bus.out_valid), 32'd0);
      check("redir_addr", 32'(bus.rom_addr), 32'd8);
      run(0, 100);

      // Whole ROM without a zero word, then replay from DONE.
      redirect(32'h0);
      pop_cyc.delete();
      run(0, 100);
      check("rom_end_pops", 32'(pop_cyc.size()), 32'(DEPTH));
      redirect(32'h0);
      @(negedge clk);
      check("replay_complete", 32'(bus.fetch_complete), 32'd0);
      run(1, 300);

      // Asynchronous reset mid-stream.
      load_random(12);
      redirect(32'h0);
      cycles(1, 6);
      @(posedge clk); #3;
      reset = 1'b1;
      hold_exempt = 1;
      #1;
      check("async_valid", 32'(bus.out_valid), 32'd0);
      check("async_complete", 32'(bus.fetch_complete), 32'd0);
      expect_from(RPC);
      #3 reset = 1'b0;
      run(1, 300);

      // Out-of-range redirect drains straight to DONE.
      pop_cyc.delete();
      redirect(32'h0000_0100);
      run(1, 20);
      check("oob_pops", 32'(pop_cyc.size()), 32'd0);

      // Random redirects interleaved with random backpressure.
      for (int it = 0; it < 6; it++) begin
         load_random($urandom_range(2, DEPTH));
         redirect(32'($urandom_range(0, DEPTH * 4 + 8)));
         cycles(1, $urandom_range(0, 8));
         redirect(32'($urandom_range(0, DEPTH * 4 - 1)));
         run(1, 300);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 256, meaning instruction ROM depth in 32-bit words.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning byte address of the first fetch.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 SHALL have port rom_addr, output, $clog2(ROM_DEPTH), meaning ROM word index (pc[..:2]).
REQ-006 SHALL have port rom_data, input, 32, meaning ROM word in file byte order {b0,b1,b2,b3}, valid one cycle after rom_addr.
REQ-007 SHALL have port out_valid, output, 1, meaning out_instr/out_pc hold a fetched instruction.
REQ-008 SHALL have port out_ready, input, 1, meaning the decode stage accepts this cycle.
REQ-009 SHALL have port out_instr, output, 32, meaning the instruction, little-endian assembled.
REQ-010 SHALL have port out_pc, output, 32, meaning the byte address of out_instr.
REQ-011 SHALL have port redirect_valid, input, 1, meaning flush and restart fetch.
REQ-012 SHALL have port redirect_pc, input, 32, meaning restart byte address; bits [1:0] ignored.
REQ-013 SHALL have port fetch_complete, output, 1, meaning program end reached and all instructions delivered.

Function
REQ-014 SHALL assemble out_instr = {rom_data[7:0], rom_data[15:8], rom_data[23:16], rom_data[31:24]}.
REQ-015 SHALL have a synchronous-read ROM model: request on issue cycle N, rom_data captured into the buffer at the edge ending cycle N+1.
REQ-016 SHALL buffer responses in a 2-entry FIFO carrying {pc, instr}; out_valid = FIFO non-empty; the head is presented on the outputs.
REQ-017 SHALL pop the head on the edge where out_valid && out_ready.
REQ-018 SHALL issue a request in a cycle only if (occupancy - pop_this_cycle + in_flight) < 2, then increment pc by 4.
REQ-019 SHALL sustain one instruction per cycle with out_ready held high.
REQ-020 SHALL hold out_instr/out_pc stable while out_valid && !out_ready.
REQ-021 SHALL use states FETCH, DRAIN, DONE; reset enters FETCH.
REQ-022 FETCH -> DRAIN when a returned assembled word equals 32'h0000_0000; that word is not enqueued and issuing stops.
REQ-023 FETCH -> DRAIN after the request for word index ROM_DEPTH-1 is issued; pc never wraps.
REQ-024 DRAIN: no issue; the in-flight response is enqueued unless it is the zero word; DRAIN -> DONE when FIFO empty and nothing in flight.
REQ-025 DONE: fetch_complete = 1, out_valid = 0, no issue; held until reset or redirect.
REQ-026 redirect_valid SHALL, on that edge, empty the FIFO, discard any in-flight response, set pc = {redirect_pc[31:2], 2'b00}, enter FETCH; out_valid = 0 next cycle.
REQ-027 redirect_valid coincident with a pop SHALL take priority; the popped instruction counts as consumed.
REQ-028 redirect_pc at or beyond ROM_DEPTH*4 SHALL enter DRAIN directly with no issue.

Reset
REQ-029 reset SHALL asynchronously force pc = RESET_PC, FIFO empty, in_flight = 0, state = FETCH, out_valid = 0, fetch_complete = 0, out_instr = 0, out_pc = 0.
REQ-030 reset asserted mid-operation SHALL discard all buffered and in-flight instructions; first issue is in the first cycle after deassertion.

Structure
REQ-031 A shared package SHALL hold the state enum (FETCH/DRAIN/DONE), instruction width 32, and the end-of-program constant 32'h0000_0000.
REQ-032 The 2-entry FIFO SHALL be a sub-module named fetch_fifo (parameterized width, clear input); the ROM stays outside this block.

Verification
REQ-033 ROM {13,05,10,00}, {93,05,20,00}, then zero; out_ready=1 -> out_instr 32'h00100513 @pc 0, then 32'h00200593 @pc 4 on consecutive cycles; fetch_complete rises afterwards; zero word never output.
REQ-034 out_ready=0 for 5 cycles after first out_valid -> outputs stable, at most 2 ROM requests outstanding+buffered, no instruction lost or duplicated on release.
REQ-035 redirect_valid with redirect_pc=32'h0000_0023 while FIFO full -> next cycle out_valid=0, rom_addr=8, next output pc 32'h20.
REQ-036 ROM with no zero word, ROM_DEPTH=4 -> exactly 4 instructions pc 0..12, then fetch_complete=1, rom_addr never wraps to 0.
REQ-037 reset pulsed asynchronously mid-stream between edges -> out_valid=0 immediately; restart from RESET_PC with no stale instruction.
REQ-038 redirect in DONE to pc 0 -> fetch_complete=0 next cycle, program replays from pc 0.
